// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
//
// Conditions raw board slide switches before they reach the downstream lab
// logic. Each bit goes through a two-flop synchroniser, then a stability
// counter that only accepts a new level after it has persisted for
// DEBOUNCE_CYCLES consecutive edges. The accepted level is registered and
// paired with one-cycle rise/fall pulses.
//
// Parameters:
//   WIDTH            number of switch bits (default 8)
//   DEBOUNCE_CYCLES  edges a changed level must persist, 2..65535 (default 16)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   sw_raw     in   raw bouncy switch levels (asynchronous)
//   sw_clean   out  debounced levels
//   sw_rise    out  one-cycle pulse on sw_clean 0->1, per bit
//   sw_fall    out  one-cycle pulse on sw_clean 1->0, per bit
//   sw_toggle  out  push-on/push-off state per bit (optional feature)
//   busy       out  high while any debounce counter is nonzero
//
// Optional feature macro: SWCOND_TOGGLE_EN
//   defined     -> sw_toggle[i] inverts whenever sw_rise[i] is high
//   not defined -> sw_toggle is constant zero, no toggle registers built
// -----------------------------------------------------------------------------
module switch_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on which a persisting change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;
  logic [WIDTH-1:0]            clean_q;
  logic [WIDTH-1:0]            clean_d;
  logic [WIDTH-1:0]            rise_q;
  logic [WIDTH-1:0]            rise_d;
  logic [WIDTH-1:0]            fall_q;
  logic [WIDTH-1:0]            fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            cnt_nz;

  // Per-bit debounce decision: a differing level counts up, a matching level
  // (including a bounce back) clears the count, and the last count accepts.
  always_comb begin
    clean_d = clean_q;
    rise_d  = {WIDTH{1'b0}};
    fall_d  = {WIDTH{1'b0}};
    cnt_d   = cnt_q;
    cnt_nz  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nz[i] = (cnt_q[i] != CNT_ZERO);
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = CNT_ZERO;
        clean_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Synchroniser, counters, clean level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {WIDTH{1'b0}};
      sync2_q <= {WIDTH{1'b0}};
      clean_q <= {WIDTH{1'b0}};
      rise_q  <= {WIDTH{1'b0}};
      fall_q  <= {WIDTH{1'b0}};
      cnt_q   <= '{default: CNT_ZERO};
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SWCOND_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q;

  // Push-on/push-off: flip on every edge that sees a rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= {WIDTH{1'b0}};
    end else begin
      toggle_q <= toggle_q ^ rise_q;
    end
  end

  assign sw_toggle = toggle_q;
`else
  assign sw_toggle = {WIDTH{1'b0}};
`endif

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign busy     = |cnt_nz;

endmodule

// File: tb/tb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// Self-checking bench for switch_conditioner (WIDTH=8, DEBOUNCE_CYCLES=4).
// Each accepted change is predicted when the raw level is driven and queued
// with the edge on which its pulse must appear; a negedge monitor pops and
// compares whenever the DUT shows a pulse, and flags pulses nobody expected.
// -----------------------------------------------------------------------------
module tb_switch_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    int         edge_n;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] clean;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic [W-1:0] sw_toggle;
  logic         busy;

  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];
  logic [7:0] cl_model;
  logic [7:0] tog_exp;
  logic [7:0] tog_pend;

  switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_toggle (sw_toggle),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges since time zero.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Predict the accepted change for a newly driven raw level.
  task automatic push_exp(input logic [7:0] v);
    exp_t e;
    e.edge_n = cyc + 1 + 1 + D;
    e.rise   = v & ~cl_model;
    e.fall   = ~v & cl_model;
    e.clean  = v;
    cl_model = v;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] v, output int n0);
    @(negedge clk);
    sw_raw = v;
    n0 = cyc + 1;
    push_exp(v);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: pulses are compared against the queued predictions.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      tog_exp  = 8'h00;
      tog_pend = 8'h00;
    end else begin
      tog_exp  = tog_exp ^ tog_pend;
      tog_pend = 8'h00;
      check("toggle", sw_toggle, tog_exp);
      if ((sw_rise | sw_fall) != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {sw_rise, sw_fall}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_edge", cyc, e.edge_n);
          check("rise", sw_rise, e.rise);
          check("fall", sw_fall, e.fall);
          check("clean", sw_clean, e.clean);
`ifdef SWCOND_TOGGLE_EN
          tog_pend = e.rise;
`endif
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].edge_n) begin
        check("missed_pulse", cyc, exp_q[0].edge_n);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int n0;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    cl_model = 8'h00;
    tog_exp  = 8'h00;
    tog_pend = 8'h00;
    rst      = 1'b1;
    sw_raw   = 8'hFF;

    // Reset held with all switches high: everything stays zero.
    repeat (3) @(negedge clk);
    check("rst_clean", sw_clean, 8'h00);
    check("rst_rise", sw_rise, 8'h00);
    check("rst_fall", sw_fall, 8'h00);
    check("rst_toggle", sw_toggle, 8'h00);
    check("rst_busy", busy, 1'b0);

    // Release: 0xFF must qualify 2+D edges later.
    @(negedge clk);
    rst = 1'b0;
    cl_model = 8'h00;
    push_exp(8'hFF);
    wait_drain();
    check("clean_after_rst", sw_clean, 8'hFF);

    drive(8'h00, n0);
    wait_drain();

    // Clean step on bit 2, with busy window N+2..N+4.
    drive(8'h04, n0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("busy_step", busy, (cyc >= n0 + 2 && cyc <= n0 + 4) ? 1'b1 : 1'b0);
    end
    wait_drain();
    check("clean_step", sw_clean, 8'h04);

    // Bounce on bit 3: each high lasts 2 cycles, never accepted.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      sw_raw[3] = (r % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("bounce_busy", busy, 1'b0);
    check("bounce_clean", sw_clean, 8'h04);

    // Simultaneous rises and falls on the same edge.
    drive(8'h0F, n0);
    wait_drain();
    drive(8'hF0, n0);
    wait_drain();
    check("simul_clean", sw_clean, 8'hF0);

    // Reset mid-debounce on bit 0: pending change discarded.
    @(negedge clk);
    sw_raw = 8'hF1;
    repeat (4) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_clean", sw_clean, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_pulse", {sw_rise, sw_fall}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cl_model = 8'h00;
    push_exp(8'hF1);
    wait_drain();
    check("mid_clean_after", sw_clean, 8'hF1);

    // Three accepted rises on bit 5.
    for (int t = 0; t < 3; t++) begin
      drive(8'hD1, n0);
      wait_drain();
      drive(8'hF1, n0);
      wait_drain();
    end
    repeat (2) @(negedge clk);
    check("toggle_final", sw_toggle, tog_exp);
    check("final_clean", sw_clean, 8'hF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
